// File: rtl/serial_comparator_pkg.sv
// serial_comparator_pkg: shared state/result types and helpers for the serial comparator
package comparator_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {EQ = 2'd0, GT = 2'd1, LT = 2'd2} res_t;
  typedef struct packed {
    logic equal;
    logic greater;
    logic lower;
  } flags_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic flags_t decode(input res_t r);
    return '{equal: r == EQ, greater: r == GT, lower: r == LT};
  endfunction
endpackage

// File: rtl/serial_comparator_chunk_cmp.sv
// chunk_cmp: combinational CHUNK-bit compare, MSB optionally flipped for signed operands
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip,
  output logic             eq,
  output logic             gt
);
  logic [CHUNK-1:0] m, xa, xb;
  assign m  = CHUNK'(flip) << (CHUNK - 1);
  assign xa = a ^ m;
  assign xb = b ^ m;
  assign eq = xa == xb;
  assign gt = xa > xb;
endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first multi-cycle magnitude compare; SERIAL_COMPARATOR_EARLY_EXIT_EN finishes on the first differing chunk
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_cmp,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lower
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW = $clog2(NCHUNK) + 1;
  state_t state;
  res_t res, nres;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic sgn, ceq, cgt, first, last, fin;
  assign first = cnt == CW'(NCHUNK);
  assign last  = cnt == CW'(1);
  chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
    .a   (sa[WIDTH-1 -: CHUNK]),
    .b   (sb[WIDTH-1 -: CHUNK]),
    .flip(sgn && first),
    .eq  (ceq),
    .gt  (cgt)
  );
  // first differing chunk decides; later chunks keep the decided result
  always_comb nres = (res == EQ && !ceq) ? (cgt ? GT : LT) : res;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign fin = last || (res == EQ && !ceq);
`else
  assign fin = last;
`endif
  // control FSM with shift registers and registered flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
      lower   <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      sgn     <= 1'b0;
      res     <= EQ;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= COMPARE;
          busy  <= 1'b1;
          sa    <= a;
          sb    <= b;
          sgn   <= signed_cmp;
          res   <= EQ;
          cnt   <= CW'(NCHUNK);
        end
        COMPARE: begin
          sa  <= sa << CHUNK;
          sb  <= sb << CHUNK;
          cnt <= cnt - CW'(1);
          res <= nres;
          if (fin) begin
            state <= DONE;
            done  <= 1'b1;
            {equal, greater, lower} <= decode(nres);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed checks of flags, latency, handshake and reset abort
module tb_serial_comparator;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_cmp = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, equal, greater, lower;
  int compared = 0, mismatched = 0, pulses = 0;
  int p0, lat;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam int E1 = 1;
`else
  localparam int E1 = 4;
`endif

  serial_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .signed_cmp(signed_cmp),
    .busy(busy), .done(done), .equal(equal), .greater(greater), .lower(lower)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic s,
                     input logic [2:0] eflags, input int elat);
    @(negedge clk);
    a = ta; b = tb_; signed_cmp = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pulses;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done();
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " flags eq/gt/lt"}, 32'({equal, greater, lower}), 32'(eflags));
    @(posedge clk); #1;
    chk({tag, " done cleared"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " one pulse"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'({busy, done, equal, greater, lower}), 32'd0);
    rst_n = 1'b1;
    run("eq 1234", 16'h1234, 16'h1234, 1'b0, 3'b100, 4);
    run("u 8000>7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b010, E1);
    run("s 8000<7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001, E1);
    run("s ffff<0001", 16'hFFFF, 16'h0001, 1'b1, 3'b001, E1);
    run("u ffff>0001", 16'hFFFF, 16'h0001, 1'b0, 3'b010, E1);
    run("u 1235>1234", 16'h1235, 16'h1234, 1'b0, 3'b010, 4);
    // start held high through COMPARE and DONE with different operands
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; signed_cmp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    p0 = pulses;
    a = 16'hFFFF; b = 16'h0000;
    wait_done();
    chk("busy start latency", 32'(lat), 32'd4);
    chk("busy start flags", 32'({equal, greater, lower}), 32'b001);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start in DONE ignored", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("single pulse held start", 32'(pulses - p0), 32'd1);
    chk("flags held", 32'({equal, greater, lower}), 32'b001);
    // async reset mid-compare
    @(negedge clk);
    a = 16'h1235; b = 16'h1234; signed_cmp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pulses;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort outputs", 32'({busy, done, equal, greater, lower}), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort no done", 32'(pulses - p0), 32'd0);
    rst_n = 1'b1;
    run("after reset s ffff<0001", 16'hFFFF, 16'h0001, 1'b1, 3'b001, E1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
